i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
- I2S slave receiver for the ADC/codec input path; the receive-side counterpart of the I2S transmitter.
- Runs entirely on input_clk (12.288 MHz) and oversamples an externally driven serial_clk (3.072 MHz, 4 input_clk cycles per bit).
- Deserialises 32-bit left/right slots and presents one aligned stereo pair of SAMPLE_WIDTH-bit samples per 48 kHz frame, with a valid strobe and framing-error detection.

Parameters:
SAMPLE_WIDTH, 16, data bits captured per slot, MSB first; remaining slot bits ignored
SLOT_BITS, 32, serial_clk periods per channel slot; frame = 2*SLOT_BITS
SYNC_STAGES, 2, synchroniser flops on serial_clk, word_select and sound_bit_in

Ports:
input_clk  in  1  system clock, 12.288 MHz
reset  in  1  asynchronous, active-high reset
serial_clk  in  1  I2S bit clock from the external master, asynchronous to input_clk
word_select  in  1  I2S WS; 0 = left slot, 1 = right slot
sound_bit_in  in  1  I2S serial data, MSB first, one bit delay after each WS change
left_sample  out  SAMPLE_WIDTH  last complete left sample, two's complement
right_sample  out  SAMPLE_WIDTH  last complete right sample, paired with left_sample
sample_valid  out  1  one-cycle pulse: left_sample/right_sample updated together
frame_error  out  1  one-cycle pulse: slot length differs from SLOT_BITS
locked  out  1  high once the first WS boundary has been seen

Behaviour:
- Reset (async, any time, including mid-slot): left_sample=0, right_sample=0, sample_valid=0, frame_error=0, locked=0. Shift register, hold register, bit counter and left_ok are cleared. Synchronisers are cleared to 0.
- Synchronisation: serial_clk, word_select and sound_bit_in each pass through SYNC_STAGES flops.
- Bit edge: synced serial_clk is 1 and was 0 on the previous cycle. All protocol actions occur only in the cycle a bit edge is detected.
- ws_prev: the WS value sampled at the previous bit edge.
- Boundary edge: a bit edge where sampled WS != ws_prev. Standard I2S: the data at the boundary edge is the LSB of the old slot, and the next edge carries the MSB of the new slot.
- Bit counter: width $clog2(SLOT_BITS)+1.
  - Set to 0 at every boundary edge.
  - Incremented at every other bit edge, saturating at SLOT_BITS.
  - The counter value counts the data bits of the current slot already received.
- Capture: at a non-boundary bit edge with counter < SAMPLE_WIDTH, shift sound_bit_in into the LSB of the shift register. Only when locked=1.
- Slot complete: the edge where the counter goes SAMPLE_WIDTH-1 -> SAMPLE_WIDTH.
  - In a left slot (WS=0): copy the shift register value into the hold register and set left_ok=1.
  - In a right slot (WS=1) with left_ok=1, on the next cycle: left_sample<=hold, right_sample<=shift value, sample_valid=1 for one cycle, left_ok<=0.
  - In a right slot with left_ok=0: no output update and no pulse. Pairs are strictly left-then-right within one frame.
- Boundary check: at a boundary edge with locked=1, the counter must equal SLOT_BITS-1.
  - Otherwise frame_error pulses one cycle later and left_ok is cleared.
  - Data capture resynchronises on the new slot regardless of the error.
- Lock: locked is set at the first boundary edge after reset. That first boundary never raises frame_error.
- WS entering a left slot clears left_ok; a left slot shorter than SAMPLE_WIDTH bits leaves left_ok=0.
- Latency: the sample_valid pulse occurs SYNC_STAGES+2 input_clk cycles after the serial_clk rising edge at the pin that carried right-slot data bit SAMPLE_WIDTH-1 (the LSB of the captured field).
- Held outputs: left_sample and right_sample hold their values between pulses.
- Simultaneous events: a boundary edge takes priority over capture; the boundary bit is never shifted into the new slot.
- serial_clk stopped: no state change; locked stays 1.

Test Plan:
1. Nominal frames: reset 5 cycles, then 3 standard frames (serial_clk = 4 input_clk periods, 32 bits/slot) with L=16'h8001, R=16'h7FFE. Expect exactly 2 sample_valid pulses (first frame only locks), each with left_sample=8001, right_sample=7FFE, and frame_error never asserting. Also measure the pulse SYNC_STAGES+2 cycles after the pin edge of right bit 15.
2. Stream values: send frames L=0x1234/R=0xABCD, then L=0xFFFF/R=0x0000. Outputs update to each pair exactly at its pulse and hold between pulses.
3. Short slot: one left slot of 20 bits. Expect a frame_error pulse at the following boundary, no sample_valid for that frame, and normal pairs resuming on the next full frame.
4. Long slot: one right slot of 40 bits. Expect frame_error at the next boundary, the counter saturates without wrap, and the next frame is valid.
5. Right-only start: release reset mid-left-slot. Expect no sample_valid until a complete left slot followed by a complete right slot has been received.
6. Reset mid-right-slot after bit 8: all outputs return to 0 and locked=0. After reset release, the first boundary produces no frame_error, and the first pulse follows the next full frame.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples an external bit clock on input_clk.
// It deserialises left/right slots and presents aligned stereo pairs, with framing-error detection.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    input_clk,
    input  logic                    reset,
    input  logic                    serial_clk,
    input  logic                    word_select,
    input  logic                    sound_bit_in,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    frame_error,
    output logic                    locked
);

    localparam int CNT_W = $clog2(SLOT_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_SAMPLE_LAST = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE      = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SLOT_LAST   = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_MAX    = CNT_W'(SLOT_BITS);

    // IDLE: no bit edge seen yet, so there is no previous WS to compare against.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOCKED
    } lock_state_t;

    lock_state_t state, state_next;

    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  ws_sync;
    logic [SYNC_STAGES-1:0]  sd_sync;
    logic                    sclk_prev;
    logic                    ws_prev;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] shift_next;
    logic [SAMPLE_WIDTH-1:0] hold_reg;
    logic                    left_ok;
    logic                    pair_pending;

    logic sclk_s;
    logic ws_s;
    logic sd_s;
    logic bit_edge;
    logic boundary;
    logic is_locked;
    logic capture;
    logic slot_done;
    logic bad_slot;

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync[0] <= serial_clk;
            ws_sync[0]   <= word_select;
            sd_sync[0]   <= sound_bit_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                ws_sync[i]   <= ws_sync[i-1];
                sd_sync[i]   <= sd_sync[i-1];
            end
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ws_s      = ws_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign bit_edge  = sclk_s & ~sclk_prev;
    assign is_locked = (state == ST_LOCKED);
    assign locked    = is_locked;

    // A boundary edge carries the old slot's LSB, so it never feeds the shifter.
    assign boundary   = bit_edge && (state != ST_IDLE) && (ws_s != ws_prev);
    assign capture    = bit_edge && !boundary && is_locked && (bit_cnt < CNT_SAMPLE);
    assign slot_done  = capture && (bit_cnt == CNT_SAMPLE_LAST);
    assign bad_slot   = boundary && is_locked && (bit_cnt != CNT_SLOT_LAST);
    assign shift_next = capture ? SAMPLE_WIDTH'({shift_reg, sd_s}) : shift_reg;

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (bit_edge) state_next = ST_HUNT;
            ST_HUNT:   if (boundary) state_next = ST_LOCKED;
            ST_LOCKED: state_next = ST_LOCKED;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Protocol datapath; the output pair is published the cycle after the right slot completes.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            hold_reg     <= '0;
            left_ok      <= 1'b0;
            pair_pending <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sample_valid <= pair_pending;
            pair_pending <= 1'b0;
            frame_error  <= 1'b0;
            shift_reg    <= shift_next;

            if (pair_pending) begin
                left_sample  <= hold_reg;
                right_sample <= shift_reg;
            end

            if (bit_edge) begin
                ws_prev <= ws_s;
                if (boundary) begin
                    bit_cnt <= '0;
                    if (!ws_s) begin
                        left_ok <= 1'b0;
                    end
                    if (bad_slot) begin
                        frame_error <= 1'b1;
                        left_ok     <= 1'b0;
                    end
                end else if (bit_cnt != CNT_SLOT_MAX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (slot_done) begin
                if (!ws_s) begin
                    hold_reg <= shift_next;
                    left_ok  <= 1'b1;
                end else if (left_ok) begin
                    pair_pending <= 1'b1;
                    left_ok      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: a frame table plus hand-written reset corner cases.
module tb_i2s_receiver;

    logic        input_clk = 1'b0;
    logic        reset;
    logic        serial_clk;
    logic        word_select;
    logic        sound_bit_in;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        frame_error;
    logic        locked;

    i2s_receiver #(
        .SAMPLE_WIDTH(16),
        .SLOT_BITS   (32),
        .SYNC_STAGES (2)
    ) dut (
        .input_clk   (input_clk),
        .reset       (reset),
        .serial_clk  (serial_clk),
        .word_select (word_select),
        .sound_bit_in(sound_bit_in),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .frame_error (frame_error),
        .locked      (locked)
    );

    always #5 input_clk = ~input_clk;

    int cycleCount = 0;
    always @(posedge input_clk) cycleCount <= cycleCount + 1;

    int checks = 0;
    int passes = 0;
    int pulseCount = 0;
    int errCount = 0;
    int holdViolations = 0;
    int lastPulseCycle = 0;
    int markCycle = 0;
    logic [15:0] lastPulseL = '0;
    logic [15:0] lastPulseR = '0;
    logic [15:0] heldL = '0;
    logic [15:0] heldR = '0;
    logic [15:0] pendL = '0;
    logic [15:0] pendR = '0;
    bit   pendArmed = 1'b0;
    logic lastBit = 1'b0;

    typedef struct {
        logic [15:0] leftData;
        logic [15:0] rightData;
        int          leftBits;
        int          rightBits;
        int          expPulses;
        int          expErrors;
        bit          checkLatency;
    } frameVec_t;

    frameVec_t vecs[10];

    // Pulse/error monitor; between pulses outputs must keep the last expected pair.
    always @(negedge input_clk) begin
        if (!reset) begin
            if (sample_valid) begin
                pulseCount++;
                lastPulseL = left_sample;
                lastPulseR = right_sample;
                lastPulseCycle = cycleCount;
                if (pendArmed) begin
                    heldL = pendL;
                    heldR = pendR;
                    pendArmed = 1'b0;
                end
            end else if (left_sample !== heldL || right_sample !== heldR) begin
                holdViolations++;
            end
            if (frame_error) errCount++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    function automatic logic slotBit(input logic [15:0] d, input int k);
        return (k < 16) ? d[15-k] : 1'b0;
    endfunction

    task automatic sendBit(input logic ws, input logic sd, input bit mark);
        @(posedge input_clk); #2;
        serial_clk   = 1'b0;
        word_select  = ws;
        sound_bit_in = sd;
        @(posedge input_clk);
        @(posedge input_clk); #2;
        serial_clk = 1'b1;
        if (mark) markCycle = cycleCount;
    endtask

    // Period 0 of a slot carries the previous slot's last bit (one-bit I2S delay).
    task automatic sendSlot(input logic ws, input logic [15:0] d, input int nbits,
                            input int fromP, input int toP);
        for (int p = fromP; p < toP; p++) begin
            sendBit(ws, (p == 0) ? lastBit : slotBit(d, p - 1), ws && (p == 16));
        end
        if (toP == nbits) lastBit = slotBit(d, nbits - 1);
    endtask

    task automatic applyStimulus(input frameVec_t v);
        sendSlot(1'b0, v.leftData, v.leftBits, 0, v.leftBits);
        sendSlot(1'b1, v.rightData, v.rightBits, 0, v.rightBits);
    endtask

    task automatic assertReset();
        @(posedge input_clk); #2;
        reset = 1'b1;
        heldL = '0;
        heldR = '0;
        pendArmed = 1'b0;
    endtask

    task automatic releaseReset();
        @(posedge input_clk); #2;
        reset = 1'b0;
    endtask

    task automatic runFrame(input string tag, input frameVec_t v);
        int p0;
        int e0;
        p0 = pulseCount;
        e0 = errCount;
        if (v.expPulses > 0) begin
            pendL = v.leftData;
            pendR = v.rightData;
            pendArmed = 1'b1;
        end
        applyStimulus(v);
        checkOutput({tag, " pulses"}, 32'(pulseCount - p0), 32'(v.expPulses));
        checkOutput({tag, " errors"}, 32'(errCount - e0), 32'(v.expErrors));
        if (v.expPulses > 0) begin
            checkOutput({tag, " left"}, 32'(lastPulseL), 32'(v.leftData));
            checkOutput({tag, " right"}, 32'(lastPulseR), 32'(v.rightData));
        end
        if (v.checkLatency) begin
            checkOutput({tag, " latency"}, 32'(lastPulseCycle - markCycle), 32'd4);
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        checks++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        int p0;
        int e0;
        frameVec_t v;

        reset        = 1'b1;
        serial_clk   = 1'b0;
        word_select  = 1'b0;
        sound_bit_in = 1'b0;
        repeat (5) @(posedge input_clk);
        @(negedge input_clk);
        checkOutput("reset left", 32'(left_sample), 32'h0);
        checkOutput("reset right", 32'(right_sample), 32'h0);
        checkOutput("reset valid", 32'(sample_valid), 32'h0);
        checkOutput("reset error", 32'(frame_error), 32'h0);
        checkOutput("reset locked", 32'(locked), 32'h0);
        releaseReset();
        repeat (3) @(posedge input_clk);

        // leftData, rightData, leftBits, rightBits, expPulses, expErrors, checkLatency
        vecs[0] = '{16'h8001, 16'h7FFE, 32, 32, 0, 0, 1'b0};
        vecs[1] = '{16'h8001, 16'h7FFE, 32, 32, 1, 0, 1'b1};
        vecs[2] = '{16'h8001, 16'h7FFE, 32, 32, 1, 0, 1'b1};
        vecs[3] = '{16'h1234, 16'hABCD, 32, 32, 1, 0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0000, 32, 32, 1, 0, 1'b0};
        vecs[5] = '{16'h5555, 16'hAAAA, 20, 32, 0, 1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 32, 32, 1, 0, 1'b0};
        vecs[7] = '{16'h1357, 16'h2468, 32, 40, 1, 0, 1'b1};
        vecs[8] = '{16'h8000, 16'h0001, 32, 32, 1, 1, 1'b0};
        vecs[9] = '{16'h7FFF, 16'h8000, 32, 32, 1, 0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            runFrame($sformatf("row%0d", i), vecs[i]);
            if (i == 0) checkOutput("row0 locked", 32'(locked), 32'h1);
        end

        p0 = pulseCount;
        e0 = errCount;
        repeat (40) @(posedge input_clk);
        @(negedge input_clk);
        checkOutput("stopped locked", 32'(locked), 32'h1);
        checkOutput("stopped pulses", 32'(pulseCount - p0), 32'h0);
        checkOutput("stopped errors", 32'(errCount - e0), 32'h0);

        // Release reset in the middle of a left slot: the next right slot must not pair.
        assertReset();
        sendSlot(1'b0, 16'h1111, 32, 0, 12);
        releaseReset();
        p0 = pulseCount;
        e0 = errCount;
        sendSlot(1'b0, 16'h1111, 32, 12, 32);
        sendSlot(1'b1, 16'h2222, 32, 0, 32);
        checkOutput("midleft pulses", 32'(pulseCount - p0), 32'h0);
        checkOutput("midleft errors", 32'(errCount - e0), 32'h0);
        checkOutput("midleft locked", 32'(locked), 32'h1);
        v = '{16'h4444, 16'h5555, 32, 32, 1, 0, 1'b1};
        runFrame("midleft frame", v);

        // Reset during a right slot after bit 8.
        sendSlot(1'b0, 16'h1111, 32, 0, 32);
        sendSlot(1'b1, 16'h2222, 32, 0, 9);
        assertReset();
        #1;
        checkOutput("midright left", 32'(left_sample), 32'h0);
        checkOutput("midright right", 32'(right_sample), 32'h0);
        checkOutput("midright valid", 32'(sample_valid), 32'h0);
        checkOutput("midright locked", 32'(locked), 32'h0);
        sendSlot(1'b1, 16'h2222, 32, 9, 20);
        releaseReset();
        p0 = pulseCount;
        e0 = errCount;
        sendSlot(1'b1, 16'h2222, 32, 20, 32);
        checkOutput("midright pulses", 32'(pulseCount - p0), 32'h0);
        checkOutput("midright unlocked", 32'(locked), 32'h0);
        v = '{16'h9999, 16'hAAAA, 32, 32, 1, 0, 1'b1};
        runFrame("midright frame", v);
        checkOutput("midright errors", 32'(errCount - e0), 32'h0);
        checkOutput("midright relocked", 32'(locked), 32'h1);

        repeat (8) @(posedge input_clk);
        checkOutput("hold violations", 32'(holdViolations), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
